// File: rtl/hw9_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hw9_pkg : shared state encodings and defaults for hw9_sdiv      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package hw9_pkg;

  localparam int N_DEFAULT = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SHIFT = 3'd1;
  localparam state_t S_SUB   = 3'd2;
  localparam state_t S_FIX   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/hw9_sdivctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hw9_sdivctrl : Load/Shift/Sub/Fix sequencer and iteration count |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module hw9_sdivctrl
  import hw9_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       div_zero,
  output logic       load,
  output logic       shift,
  output logic       sub,
  output logic       fix,
  output logic       done,
  output logic       ready,
  output logic [2:0] state
);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_cnt_last;

  assign w_cnt_last = (r_cnt == CW'(1));
  assign state      = r_state;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset)     r_cnt <= '0;
    else if (load)  r_cnt <= CW'(N);
    else if (sub)   r_cnt <= r_cnt - CW'(1);
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? (div_zero ? S_DONE : S_SHIFT) : S_IDLE;
      S_SHIFT: w_next = S_SUB;
      S_SUB:   w_next = w_cnt_last ? S_FIX : S_SHIFT;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    sub   = 1'b0;
    fix   = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_IDLE:  load  = start;
      S_SHIFT: shift = 1'b1;
      S_SUB:   sub   = 1'b1;
      S_FIX:   fix   = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
    ready = (r_state == S_IDLE) && reset;
  end

endmodule
`default_nettype wire

// File: rtl/hw9_sdiv.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hw9_sdiv : sequential signed restoring divider, R/Q/D datapath  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module hw9_sdiv
  import hw9_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Ready,
  output logic         Done,
  output logic         DivZero,
  output logic         Ovf,
  output logic [2:0]   state
);

  localparam logic [N-1:0] c_min_neg = {1'b1, {(N-1){1'b0}}};

  logic [N:0]   r_rem;
  logic [N-1:0] r_q;
  logic [N-1:0] r_d;
  logic         r_sq;
  logic         r_sr;

  logic         w_load, w_shift, w_sub, w_fix;
  logic         w_div_zero;
  logic         w_ovf;
  logic [N-1:0] w_dvd_mag;
  logic [N-1:0] w_dvs_mag;
  logic [N:0]   w_trial;

  // Magnitudes are unsigned N-bit, so the most negative operand maps exactly.
  assign w_dvd_mag  = Dividend[N-1] ? (~Dividend + 1'b1) : Dividend;
  assign w_dvs_mag  = Divisor[N-1]  ? (~Divisor + 1'b1)  : Divisor;
  assign w_div_zero = (Divisor == '0);
  assign w_ovf      = (Dividend == c_min_neg) && (Divisor == '1);
  assign w_trial    = r_rem - {1'b0, r_d};

  hw9_sdivctrl #(
    .N  (N),
    .CW (CW)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (Start),
    .div_zero (w_div_zero),
    .load     (w_load),
    .shift    (w_shift),
    .sub      (w_sub),
    .fix      (w_fix),
    .done     (Done),
    .ready    (Ready),
    .state    (state)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_sq      <= 1'b0;
      r_sr      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      if (w_load) begin
        r_q     <= w_dvd_mag;
        r_d     <= w_dvs_mag;
        r_rem   <= '0;
        r_sq    <= Dividend[N-1] ^ Divisor[N-1];
        r_sr    <= Dividend[N-1];
        DivZero <= w_div_zero;
        Ovf     <= w_ovf;
        if (w_div_zero) begin
          Quotient  <= '0;
          Remainder <= Dividend;
        end
      end
      if (w_shift) begin
        r_rem <= {r_rem[N-1:0], r_q[N-1]};
        r_q   <= {r_q[N-2:0], 1'b0};
      end
      // A negative trial means the divisor did not fit: keep R (restore).
      if (w_sub) begin
        if (!w_trial[N]) begin
          r_rem  <= w_trial;
          r_q[0] <= 1'b1;
        end else begin
          r_q[0] <= 1'b0;
        end
      end
      if (w_fix) begin
        Quotient  <= r_sq ? (~r_q + 1'b1) : r_q;
        Remainder <= r_sr ? (~r_rem[N-1:0] + 1'b1) : r_rem[N-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hw9_sdiv.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_hw9_sdiv : scoreboard bench for hw9_sdiv, directed vectors   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_hw9_sdiv;

  localparam int N   = 8;
  localparam int LAT = 2 * N + 1;

  logic         clk;
  logic         reset;
  logic         Start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Ready;
  logic         Done;
  logic         DivZero;
  logic         Ovf;
  logic [2:0]   state;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ovf;
    int           done_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  hw9_sdiv #(.N(N), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Ready     (Ready),
    .Done      (Done),
    .DivZero   (DivZero),
    .Ovf       (Ovf),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_q"},   32'(Quotient),  32'(e.q));
        chk({e.name, "_r"},   32'(Remainder), 32'(e.r));
        chk({e.name, "_dz"},  32'(DivZero),   32'(e.dz));
        chk({e.name, "_ovf"}, 32'(Ovf),       32'(e.ovf));
        chk({e.name, "_lat"}, 32'(cyc),       32'(e.done_cyc));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (Ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (Ready !== 1'b1) chk("ready_timeout", 32'(Ready), 32'd1);
  endtask

  // Called at a negedge; the request is sampled at the following posedge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input logic eovf, input string nm);
    exp_t e;
    wait_ready();
    e.q        = eq;
    e.r        = er;
    e.dz       = edz;
    e.ovf      = eovf;
    e.done_cyc = cyc + 1 + (edz ? 0 : LAT);
    e.name     = nm;
    sb.push_back(e);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_state"}, 32'(state),     32'd0);
    chk({tag, "_ready"}, 32'(Ready),     32'd0);
    chk({tag, "_q"},     32'(Quotient),  32'd0);
    chk({tag, "_r"},     32'(Remainder), 32'd0);
    chk({tag, "_done"},  32'(Done),      32'd0);
    chk({tag, "_dz"},    32'(DivZero),   32'd0);
    chk({tag, "_ovf"},   32'(Ovf),       32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(negedge clk);
    check_cleared("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(Ready), 32'd1);

    issue(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, "p100_p7");
    issue(8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0, "n100_p7");
    issue(8'd100, 8'hF9,  8'hF2,  8'd2,   1'b0, 1'b0, "p100_n7");
    issue(8'h9C,  8'hF9,  8'd14,  8'hFE,  1'b0, 1'b0, "n100_n7");
    issue(8'h80,  8'hFF,  8'h80,  8'd0,   1'b0, 1'b1, "min_neg1");
    issue(8'h80,  8'd1,   8'h80,  8'd0,   1'b0, 1'b0, "min_pos1");
    issue(8'd5,   8'd0,   8'd0,   8'd5,   1'b1, 1'b0, "div_zero");
    issue(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 1'b0, "after_dz");

    // A second Start during the third iteration must be ignored.
    issue(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, "busy_start");
    repeat (4) @(negedge clk);
    chk("busy_ready", 32'(Ready), 32'd0);
    Start    = 1'b1;
    Dividend = 8'd1;
    Divisor  = 8'd1;
    @(negedge clk);
    Start = 1'b0;
    drain();

    issue(8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 1'b0, "zero_dvd");
    issue(8'd7,   8'd100, 8'd0,   8'd7,   1'b0, 1'b0, "small_dvd");
    drain();

    // Abort a division with a one-edge reset; no Done may follow.
    wait_ready();
    Start    = 1'b1;
    Dividend = 8'd100;
    Divisor  = 8'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("abort");
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(Ready), 32'd1);
    repeat (25) @(negedge clk);

    issue(8'd50,  8'hFA,  8'hF8,  8'd2,   1'b0, 1'b0, "p50_n6");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
